dmem_responder: RTL and testbench

Memory-side responder for the processor's data-memory port, with a valid/ready request/response handshake. It accepts one load or store at a time, inserts a fixed number of wait states, commits the access to an internal word array, and returns read data or an error. It is the other end of the processor's load/store interface. It replaces the zero-latency array so the core can be tested against a memory that stalls.

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, WAIT_CYCLES wait states,
// then a held response carrying read data or an access error.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic        i_req_size,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_busy
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic        r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_commit;
  logic          w_write;
  logic          w_size;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_err;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_rdata;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  assign w_accept = (r_state == S_IDLE) && i_req_valid;
  // With no wait states the acceptance edge is also the commit edge, so
  // the access is decoded straight from the request ports.
  assign w_commit = (WAIT_CYCLES == 0) ? w_accept
                                       : ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_write  = (r_state == S_IDLE) ? i_req_write : r_write;
  assign w_size   = (r_state == S_IDLE) ? i_req_size  : r_size;
  assign w_addr   = (r_state == S_IDLE) ? i_req_addr  : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? i_req_wdata : r_wdata;

  assign w_idx   = w_addr[AW+1:2];
  assign w_lane  = w_addr[1:0];
  assign w_err   = (w_addr[31:AW+2] != '0) || (!w_size && (w_lane != 2'b00));
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_rdata = '0;
    if (!w_err && !w_write) begin
      w_rdata = w_size ? sext8(w_shift[7:0]) : w_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_write <= i_req_write;
      r_size  <= i_req_size;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
    end
  end

  // Array is deliberately not reset; reset only blocks a commit.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_commit && w_write && !w_err) begin
      if (w_size) begin
        r_mem[w_idx][{w_lane, 3'b000} +: 8] <= w_wdata[7:0];
      end else begin
        r_mem[w_idx] <= w_wdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_state <= S_WAIT;
            r_cnt   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_commit) begin
        r_state      <= S_RESP;
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= w_rdata;
      end
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic on a
// WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance, against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic        req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        busy      [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wcs [2] = '{2, 0};

  logic [31:0] ref_mem [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_write(req_write[0]), .i_req_size(req_size[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready[0]),
    .o_resp_rdata(resp_rdata[0]), .o_resp_err(resp_err[0]), .o_busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_write(req_write[1]), .i_req_size(req_size[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready[1]),
    .o_resp_rdata(resp_rdata[1]), .o_resp_err(resp_err[1]), .o_busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed view of a word array with little-endian lanes.
  task automatic model(input int d, input bit wr, input bit sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] r, output bit e);
    int unsigned lane;
    int unsigned idx;
    logic [31:0] w;
    logic [31:0] b;
    lane = a % 4;
    idx  = a / 4;
    e    = (a >= DEPTH * 4) || (!sz && lane != 0);
    r    = 32'h0;
    if (!e) begin
      if (wr) begin
        if (!sz) ref_mem[d][idx] = wd;
        else     ref_mem[d][idx] = (ref_mem[d][idx] & ~(32'hFF << (8 * lane)))
                                 | ((wd & 32'hFF) << (8 * lane));
      end else begin
        w = ref_mem[d][idx];
        if (!sz) r = w;
        else begin
          b = (w >> (8 * lane)) & 32'hFF;
          r = (b >= 128) ? b + 32'hFFFFFF00 : b;
        end
      end
    end
  endtask

  task automatic xact(input int d, input bit wr, input bit sz, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] er;
    bit          ee;
    int          k;
    model(d, wr, sz, a, wd, er, ee);
    check("req_ready_idle", 32'(req_ready[d]), 32'h1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = sz;
    req_addr[d]  = a;    req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    k = 0;
    while (!resp_valid[d] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("latency", 32'(k), 32'(wcs[d]));
    check("rdata", resp_rdata[d], er);
    check("err", 32'(resp_err[d]), 32'(ee));
    check("req_ready_resp", 32'(req_ready[d]), 32'h0);
    check("busy_resp", 32'(busy[d]), 32'h1);
    got = resp_rdata[d];
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    check("resp_valid_clr", 32'(resp_valid[d]), 32'h0);
    check("rdata_clr", resp_rdata[d], 32'h0);
    check("err_clr", 32'(resp_err[d]), 32'h0);
    check("req_ready_back", 32'(req_ready[d]), 32'h1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] er;
    logic [31:0] hold_rd;
    logic [31:0] a;
    bit          ee;
    bit          hold_err;
    int          k;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_write[d] = 0; req_size[d] = 0;
      req_addr[d] = 0; req_wdata[d] = 0; resp_ready[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 32'(req_ready[d]), 32'h1);
      check("rst_resp_valid", 32'(resp_valid[d]), 32'h0);
      check("rst_resp_err", 32'(resp_err[d]), 32'h0);
      check("rst_resp_rdata", resp_rdata[d], 32'h0);
      check("rst_busy", 32'(busy[d]), 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) xact(d, 1, 0, 32'(i * 4), $urandom, got);

    // Directed scenarios on the stalling instance
    xact(0, 1, 0, 32'h10, 32'hDEADBEEF, got);
    check("tp_store_rdata", got, 32'h0);
    xact(0, 0, 0, 32'h10, 32'h0, got);
    check("tp_load_deadbeef", got, 32'hDEADBEEF);
    xact(0, 1, 0, 32'h20, 32'h0, got);
    xact(0, 1, 1, 32'h22, 32'h80, got);
    xact(0, 0, 0, 32'h20, 32'h0, got);
    check("tp_word_after_byte", got, 32'h00800000);
    xact(0, 0, 1, 32'h22, 32'h0, got);
    check("tp_byte_sext", got, 32'hFFFFFF80);
    xact(0, 1, 0, 32'h13, 32'h11111111, got);
    xact(0, 0, 0, 32'h10, 32'h0, got);
    check("tp_misaligned_nowrite", got, 32'hDEADBEEF);
    xact(0, 0, 0, 32'h400, 32'h0, got);

    // Response held while resp_ready stays low; extra requests are ignored
    model(0, 1, 0, 32'h40, 32'h55, er, ee);
    req_valid[0] = 1; req_write[0] = 1; req_size[0] = 0;
    req_addr[0] = 32'h40; req_wdata[0] = 32'h55;
    @(posedge clk); #1;
    req_valid[0] = 0;
    k = 0;
    while (!resp_valid[0] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("hold_latency", 32'(k), 32'h2);
    hold_rd  = resp_rdata[0];
    hold_err = resp_err[0];
    check("hold_store_rdata", hold_rd, 32'h0);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = (i % 2 == 0); req_write[0] = 1; req_size[0] = 0;
      req_addr[0] = 32'h44; req_wdata[0] = 32'hAAAA5555;
      @(posedge clk); #1;
      check("hold_resp_valid", 32'(resp_valid[0]), 32'h1);
      check("hold_rdata", resp_rdata[0], 32'h0);
      check("hold_err", 32'(resp_err[0]), 32'(hold_err));
      check("hold_req_ready", 32'(req_ready[0]), 32'h0);
    end
    req_valid[0] = 0;
    resp_ready[0] = 1;
    @(posedge clk); #1;
    resp_ready[0] = 0;
    check("hold_release", 32'(req_ready[0]), 32'h1);
    repeat (2) begin
      @(posedge clk); #1;
      check("hold_no_extra", 32'(busy[0]), 32'h0);
    end
    xact(0, 0, 0, 32'h44, 32'h0, got);
    xact(0, 0, 0, 32'h40, 32'h0, got);
    check("hold_store_landed", got, 32'h55);

    // Reset during WAIT aborts the store
    xact(0, 1, 0, 32'h30, 32'h12345678, got);
    req_valid[0] = 1; req_write[0] = 1; req_size[0] = 0;
    req_addr[0] = 32'h30; req_wdata[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid[0] = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready[0]), 32'h1);
    check("abort_resp_valid", 32'(resp_valid[0]), 32'h0);
    check("abort_busy", 32'(busy[0]), 32'h0);
    check("abort_err", 32'(resp_err[0]), 32'h0);
    check("abort_rdata", resp_rdata[0], 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 0, 0, 32'h30, 32'h0, got);
    check("abort_mem_kept", got, 32'h12345678);

    // Zero-wait instance: response visible right after the acceptance edge
    xact(1, 1, 0, 32'h50, 32'hCAFEF00D, got);
    xact(1, 0, 1, 32'h53, 32'h0, got);
    check("w0_byte_load", got, 32'hFFFFFFCA);
    xact(1, 0, 0, 32'h402, 32'h0, got);

    // Random traffic on both instances
    for (int i = 0; i < 60; i++) begin
      int d;
      d = (i % 3 == 2) ? 1 : 0;
      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      xact(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
